lsu_dccm_bank_resp: RTL and testbench

//  Responder end of the LSU DCCM port: banked 1R1W data storage behind dccm_wren/dccm_rden.

---
 rtl/lsu_dccm_pkg.sv | 39 +++
 rtl/lsu_dccm_bank_ram.sv | 42 ++++
 rtl/lsu_dccm_bank_resp.sv | 189 ++++++++++++++++++
 tb/tb_lsu_dccm_bank_resp.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_dccm_pkg.sv
// ----------------------------------------------------------------------------
// lsu_dccm_pkg
// Shared widths, types and address-decode helpers for the LSU DCCM responder.
// Address layout (byte address):
//   [DCCM_BITS-1 -: INDEX_BITS]              row index inside a bank
//   [DCCM_WIDTH_BITS +: DCCM_BANK_BITS]      bank select
//   [DCCM_WIDTH_BITS-1:0]                    byte offset inside a bank word
// ----------------------------------------------------------------------------
package lsu_dccm_pkg;

    localparam int DCCM_BITS        = 16;
    localparam int DCCM_BYTE_WIDTH  = 4;
    localparam int DCCM_WIDTH_BITS  = $clog2(DCCM_BYTE_WIDTH);
    localparam int DCCM_BANK_BITS   = 3;
    localparam int NUM_BANKS        = 2 ** DCCM_BANK_BITS;
    localparam int DCCM_FDATA_WIDTH = 39;
    localparam int INDEX_BITS       = DCCM_BITS - DCCM_WIDTH_BITS - DCCM_BANK_BITS;
    localparam int NUM_ROWS         = 2 ** INDEX_BITS;

    typedef logic [DCCM_FDATA_WIDTH-1:0] dccm_word_t;
    typedef logic [DCCM_BANK_BITS-1:0]   bank_sel_t;
    typedef logic [INDEX_BITS-1:0]       bank_idx_t;
    typedef logic [DCCM_BITS-1:0]        dccm_addr_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INIT = 2'd1,
        DONE = 2'd2
    } init_state_e;

    function automatic bank_sel_t addr_bank(input dccm_addr_t a);
        return a[DCCM_WIDTH_BITS +: DCCM_BANK_BITS];
    endfunction

    function automatic bank_idx_t addr_index(input dccm_addr_t a);
        return a[DCCM_BITS-1 -: INDEX_BITS];
    endfunction

endpackage

// File: rtl/lsu_dccm_bank_ram.sv
// ----------------------------------------------------------------------------
// lsu_dccm_bank_ram
// One DCCM bank: 1R1W storage, synchronous write, registered read.
// A read of the row being written in the same cycle returns the old contents;
// the caller is responsible for any write-to-read bypass.
// The read register only updates when i_rd_en is high, so it holds otherwise.
// Ports:
//   clk        clock
//   i_wr_en    write enable
//   i_wr_idx   write row
//   i_wr_data  write word
//   i_rd_en    read enable
//   i_rd_idx   read row
//   o_rd_data  registered read word
// ----------------------------------------------------------------------------
import lsu_dccm_pkg::*;

module lsu_dccm_bank_ram (
    input  logic       clk,
    input  logic       i_wr_en,
    input  bank_idx_t  i_wr_idx,
    input  dccm_word_t i_wr_data,
    input  logic       i_rd_en,
    input  bank_idx_t  i_rd_idx,
    output dccm_word_t o_rd_data
);

    dccm_word_t r_mem [NUM_ROWS];
    dccm_word_t r_rd_data;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_idx] <= i_wr_data;
        end
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_idx];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/lsu_dccm_bank_resp.sv
// ----------------------------------------------------------------------------
// lsu_dccm_bank_resp
// Responder end of the LSU DCCM port. NUM_BANKS 1R1W banks accept one write
// and one lo/hi read pair per cycle; read data appears the following cycle.
// A same-cycle write to the row being read is bypassed to the read result.
// Illegal same-bank/different-row collisions zero the colliding read half and
// pulse dccm_hazard in the result cycle.
// Optional feature macro: DCCM_RESP_INIT_EN -- post-reset zero scrub of every
// row of every bank, with dccm_ready low until the scrub completes.
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   dccm_wren/wr_addr/wr_data       store-buffer write (committed this cycle)
//   dccm_rden/rd_addr_lo/rd_addr_hi read request for both halves
//   dccm_rd_data_lo/hi              read words, valid the cycle after rden
//   dccm_ready                      0 while the scrub is running
//   dccm_hazard                     one-cycle pulse on an illegal collision
// ----------------------------------------------------------------------------
import lsu_dccm_pkg::*;

module lsu_dccm_bank_resp (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        dccm_wren,
    input  logic [DCCM_BITS-1:0]        dccm_wr_addr,
    input  logic [DCCM_FDATA_WIDTH-1:0] dccm_wr_data,
    input  logic                        dccm_rden,
    input  logic [DCCM_BITS-1:0]        dccm_rd_addr_lo,
    input  logic [DCCM_BITS-1:0]        dccm_rd_addr_hi,
    output logic [DCCM_FDATA_WIDTH-1:0] dccm_rd_data_lo,
    output logic [DCCM_FDATA_WIDTH-1:0] dccm_rd_data_hi,
    output logic                        dccm_ready,
    output logic                        dccm_hazard
);

    logic      w_ready;
    logic      w_init_wr;
    bank_idx_t w_init_idx;

`ifdef DCCM_RESP_INIT_EN
    init_state_e r_state;
    init_state_e w_state_nxt;
    bank_idx_t   r_init_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_init_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == INIT) begin
                r_init_cnt <= r_init_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        w_init_wr   = 1'b0;
        case (r_state)
            IDLE: w_state_nxt = INIT;
            INIT: begin
                w_init_wr = 1'b1;
                if (&r_init_cnt) begin
                    w_state_nxt = DONE;
                end
            end
            DONE:    w_ready = 1'b1;
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_init_idx = r_init_cnt;
`else
    assign w_ready    = 1'b1;
    assign w_init_wr  = 1'b0;
    assign w_init_idx = '0;
`endif

    // Accesses presented while in reset or before ready are dropped.
    logic w_wr_ok;
    logic w_rd_ok;
    assign w_wr_ok = dccm_wren & w_ready & ~rst;
    assign w_rd_ok = dccm_rden & w_ready & ~rst;

    bank_sel_t w_wr_bank, w_lo_bank, w_hi_bank;
    bank_idx_t w_wr_idx,  w_lo_idx,  w_hi_idx;
    assign w_wr_bank = addr_bank(dccm_wr_addr);
    assign w_lo_bank = addr_bank(dccm_rd_addr_lo);
    assign w_hi_bank = addr_bank(dccm_rd_addr_hi);
    assign w_wr_idx  = addr_index(dccm_wr_addr);
    assign w_lo_idx  = addr_index(dccm_rd_addr_lo);
    assign w_hi_idx  = addr_index(dccm_rd_addr_hi);

    // Byte-offset bits never affect a word access.
    logic [3*DCCM_WIDTH_BITS-1:0] w_unused_offset;
    assign w_unused_offset = {dccm_wr_addr[DCCM_WIDTH_BITS-1:0],
                              dccm_rd_addr_lo[DCCM_WIDTH_BITS-1:0],
                              dccm_rd_addr_hi[DCCM_WIDTH_BITS-1:0]};

    // Collision classification. A same bank/same row write is a legal bypass;
    // same bank/different row on any pair is illegal. On a lo/hi collision the
    // bank serves lo and the hi half is the one zeroed.
    logic w_wr_lo_bank, w_wr_hi_bank;
    logic w_wr_lo_hit,  w_wr_hi_hit;
    logic w_zero_lo,    w_zero_hi;
    logic w_lohi_hz;
    logic w_hazard;

    assign w_wr_lo_bank = w_wr_ok && (w_wr_bank == w_lo_bank);
    assign w_wr_hi_bank = w_wr_ok && (w_wr_bank == w_hi_bank);
    assign w_wr_lo_hit  = w_wr_lo_bank && (w_wr_idx == w_lo_idx);
    assign w_wr_hi_hit  = w_wr_hi_bank && (w_wr_idx == w_hi_idx);
    assign w_lohi_hz    = (w_lo_bank == w_hi_bank) && (w_lo_idx != w_hi_idx);
    assign w_zero_lo    = w_wr_lo_bank && !w_wr_lo_hit;
    assign w_zero_hi    = (w_wr_hi_bank && !w_wr_hi_hit) || w_lohi_hz;
    assign w_hazard     = w_rd_ok && (w_zero_lo || w_zero_hi);

    dccm_word_t w_bank_rd_data [NUM_BANKS];

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic       w_bk_wr_en;
        bank_idx_t  w_bk_wr_idx;
        dccm_word_t w_bk_wr_data;
        logic       w_bk_lo_sel;
        logic       w_bk_rd_en;
        bank_idx_t  w_bk_rd_idx;

        // During the scrub every bank writes zero to the counter row at once.
        assign w_bk_wr_en   = w_init_wr | (w_wr_ok && (w_wr_bank == bank_sel_t'(b)));
        assign w_bk_wr_idx  = w_init_wr ? w_init_idx : w_wr_idx;
        assign w_bk_wr_data = w_init_wr ? '0 : dccm_wr_data;
        assign w_bk_lo_sel  = (w_lo_bank == bank_sel_t'(b));
        assign w_bk_rd_en   = w_rd_ok && (w_bk_lo_sel || (w_hi_bank == bank_sel_t'(b)));
        assign w_bk_rd_idx  = w_bk_lo_sel ? w_lo_idx : w_hi_idx;

        lsu_dccm_bank_ram u_ram (
            .clk       (clk),
            .i_wr_en   (w_bk_wr_en),
            .i_wr_idx  (w_bk_wr_idx),
            .i_wr_data (w_bk_wr_data),
            .i_rd_en   (w_bk_rd_en),
            .i_rd_idx  (w_bk_rd_idx),
            .o_rd_data (w_bank_rd_data[b])
        );
    end

    // Result-cycle steering. All of it only updates on an accepted read, so
    // the outputs hold between reads. Reset forces both halves to zero.
    logic       r_zero_lo, r_zero_hi;
    logic       r_byp_lo,  r_byp_hi;
    bank_sel_t  r_sel_lo,  r_sel_hi;
    dccm_word_t r_byp_data;
    logic       r_hazard;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_zero_lo <= 1'b1;
            r_zero_hi <= 1'b1;
            r_byp_lo  <= 1'b0;
            r_byp_hi  <= 1'b0;
            r_sel_lo  <= '0;
            r_sel_hi  <= '0;
            r_hazard  <= 1'b0;
        end else begin
            r_hazard <= w_hazard;
            if (w_rd_ok) begin
                r_zero_lo <= w_zero_lo;
                r_zero_hi <= w_zero_hi;
                r_byp_lo  <= w_wr_lo_hit;
                r_byp_hi  <= w_wr_hi_hit;
                r_sel_lo  <= w_lo_bank;
                r_sel_hi  <= w_hi_bank;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_rd_ok && (w_wr_lo_hit || w_wr_hi_hit)) begin
            r_byp_data <= dccm_wr_data;
        end
    end

    assign dccm_rd_data_lo = r_zero_lo ? '0 : (r_byp_lo ? r_byp_data : w_bank_rd_data[r_sel_lo]);
    assign dccm_rd_data_hi = r_zero_hi ? '0 : (r_byp_hi ? r_byp_data : w_bank_rd_data[r_sel_hi]);
    assign dccm_ready      = w_ready;
    assign dccm_hazard     = r_hazard;

endmodule

// File: tb/tb_lsu_dccm_bank_resp.sv
// ----------------------------------------------------------------------------
// tb_lsu_dccm_bank_resp
// Directed bench for lsu_dccm_bank_resp. Inputs change 1 time unit after the
// rising edge; outputs are sampled at the same point.
// ----------------------------------------------------------------------------
module tb_lsu_dccm_bank_resp;

    logic        clk;
    logic        rst;
    logic        dccm_wren;
    logic [15:0] dccm_wr_addr;
    logic [38:0] dccm_wr_data;
    logic        dccm_rden;
    logic [15:0] dccm_rd_addr_lo;
    logic [15:0] dccm_rd_addr_hi;
    logic [38:0] dccm_rd_data_lo;
    logic [38:0] dccm_rd_data_hi;
    logic        dccm_ready;
    logic        dccm_hazard;

    int n_chk  = 0;
    int n_fail = 0;

    lsu_dccm_bank_resp dut (
        .clk             (clk),
        .rst             (rst),
        .dccm_wren       (dccm_wren),
        .dccm_wr_addr    (dccm_wr_addr),
        .dccm_wr_data    (dccm_wr_data),
        .dccm_rden       (dccm_rden),
        .dccm_rd_addr_lo (dccm_rd_addr_lo),
        .dccm_rd_addr_hi (dccm_rd_addr_hi),
        .dccm_rd_data_lo (dccm_rd_data_lo),
        .dccm_rd_data_hi (dccm_rd_data_hi),
        .dccm_ready      (dccm_ready),
        .dccm_hazard     (dccm_hazard)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_w(input string tag, input logic [38:0] obs, input logic [38:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b, expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_i(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [15:0] a, input logic [38:0] d);
        dccm_wren    = 1'b1;
        dccm_wr_addr = a;
        dccm_wr_data = d;
    endtask

    task automatic rd(input logic [15:0] lo, input logic [15:0] hi);
        dccm_rden       = 1'b1;
        dccm_rd_addr_lo = lo;
        dccm_rd_addr_hi = hi;
    endtask

    task automatic idle();
        dccm_wren = 1'b0;
        dccm_rden = 1'b0;
    endtask

`ifdef DCCM_RESP_INIT_EN
    // Counts cycles after rst deasserts until ready; bounded.
    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (dccm_ready !== 1'b1 && n < 3000) begin
            chk_b({tag, "_hz"}, dccm_hazard, 1'b0);
            step();
            n++;
        end
        chk_i(tag, n, 2049);
    endtask
`endif

    initial begin
        rst             = 1'b1;
        dccm_wren       = 1'b0;
        dccm_wr_addr    = '0;
        dccm_wr_data    = '0;
        dccm_rden       = 1'b0;
        dccm_rd_addr_lo = '0;
        dccm_rd_addr_hi = '0;
        step();
        step();
        // A read presented during reset must be dropped.
        rd(16'h0010, 16'h0010);
        step();
        rst = 1'b0;
        idle();
        chk_w("rst_lo", dccm_rd_data_lo, 39'h0);
        chk_w("rst_hi", dccm_rd_data_hi, 39'h0);
        chk_b("rst_hz", dccm_hazard, 1'b0);
`ifdef DCCM_RESP_INIT_EN
        chk_b("rst_ready", dccm_ready, 1'b0);
        // Reads during the scrub are ignored.
        rd(16'h0010, 16'h0014);
        wait_ready("scrub_len");
        idle();
        chk_w("scrub_rd_ignored", dccm_rd_data_lo, 39'h0);
        rd(16'h0010, 16'h0014);
        step();
        idle();
        chk_w("post_scrub_lo", dccm_rd_data_lo, 39'h0);
        chk_w("post_scrub_hi", dccm_rd_data_hi, 39'h0);
`else
        chk_b("rst_ready", dccm_ready, 1'b1);
`endif

        // 1: write then read the same word on both halves.
        wr(16'h0010, 39'h5A_DEADBEEF);
        step();
        idle();
        rd(16'h0010, 16'h0010);
        step();
        idle();
        chk_w("t1_lo", dccm_rd_data_lo, 39'h5A_DEADBEEF);
        chk_w("t1_hi", dccm_rd_data_hi, 39'h5A_DEADBEEF);
        chk_b("t1_hz", dccm_hazard, 1'b0);
        step();
        step();
        chk_w("hold_lo", dccm_rd_data_lo, 39'h5A_DEADBEEF);
        chk_w("hold_hi", dccm_rd_data_hi, 39'h5A_DEADBEEF);

        // 2: unaligned pair across banks 4 and 5.
        wr(16'h0010, 39'h11_11111111);
        step();
        wr(16'h0014, 39'h22_22222222);
        step();
        idle();
        rd(16'h0012, 16'h0015);
        step();
        idle();
        chk_w("t2_lo", dccm_rd_data_lo, 39'h11_11111111);
        chk_w("t2_hi", dccm_rd_data_hi, 39'h22_22222222);
        chk_b("t2_hz", dccm_hazard, 1'b0);

        // lo/hi in the same bank word share one read.
        rd(16'h0010, 16'h0011);
        step();
        idle();
        chk_w("same_lo", dccm_rd_data_lo, 39'h11_11111111);
        chk_w("same_hi", dccm_rd_data_hi, 39'h11_11111111);
        chk_b("same_hz", dccm_hazard, 1'b0);

        // 3: write/read same row in one cycle returns the new data.
        wr(16'h0020, 39'h7F_0BADF00D);
        step();
        wr(16'h0020, 39'h01_00000001);
        rd(16'h0020, 16'h0020);
        step();
        idle();
        chk_w("t3_lo", dccm_rd_data_lo, 39'h01_00000001);
        chk_w("t3_hi", dccm_rd_data_hi, 39'h01_00000001);
        chk_b("t3_hz", dccm_hazard, 1'b0);
        rd(16'h0020, 16'h0024);
        step();
        idle();
        chk_w("t3_commit", dccm_rd_data_lo, 39'h01_00000001);

        // 4: write bank0/row0 with read bank0/row1 is illegal.
        wr(16'h0000, 39'h33_CAFEF00D);
        rd(16'h0020, 16'h0020);
        step();
        idle();
        chk_w("t4_lo", dccm_rd_data_lo, 39'h0);
        chk_w("t4_hi", dccm_rd_data_hi, 39'h0);
        chk_b("t4_hz", dccm_hazard, 1'b1);
        step();
        chk_b("t4_hz_pulse", dccm_hazard, 1'b0);
        chk_w("t4_lo_hold", dccm_rd_data_lo, 39'h0);
        rd(16'h0000, 16'h0000);
        step();
        idle();
        chk_w("t4_commit", dccm_rd_data_lo, 39'h33_CAFEF00D);
        chk_b("t4_commit_hz", dccm_hazard, 1'b0);

        // lo/hi in the same bank but different rows: hi half zeroed.
        rd(16'h0000, 16'h0020);
        step();
        idle();
        chk_w("lohi_lo", dccm_rd_data_lo, 39'h33_CAFEF00D);
        chk_w("lohi_hi", dccm_rd_data_hi, 39'h0);
        chk_b("lohi_hz", dccm_hazard, 1'b1);
        step();
        chk_b("lohi_hz_pulse", dccm_hazard, 1'b0);

        // Reset during an access drops it and clears the outputs.
        rd(16'h0010, 16'h0014);
        rst = 1'b1;
        step();
        rst = 1'b0;
        idle();
        chk_w("midrst_lo", dccm_rd_data_lo, 39'h0);
        chk_w("midrst_hi", dccm_rd_data_hi, 39'h0);
        chk_b("midrst_hz", dccm_hazard, 1'b0);

`ifdef DCCM_RESP_INIT_EN
        // 6: reassert reset at scrub index 5; timing restarts from there.
        repeat (6) step();
        chk_b("restart_ready", dccm_ready, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        wait_ready("restart_len");
        rd(16'h0000, 16'h0020);
        step();
        idle();
        chk_w("restart_lo", dccm_rd_data_lo, 39'h0);
`else
        // Storage survives reset when no scrub is built in.
        rd(16'h0000, 16'h0010);
        step();
        idle();
        chk_w("retain_lo", dccm_rd_data_lo, 39'h33_CAFEF00D);
        chk_w("retain_hi", dccm_rd_data_hi, 39'h11_11111111);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
